// File: rtl/lcd_frame_ctrl.sv
// lcd_frame_ctrl -- HD44780-class character LCD controller with its own frame buffer.
//
// Holds a ROWS x COLS character buffer. After reset it waits POR_CYC cycles and
// sends the init sequence 0x38, 0x0C, 0x06, 0x01. It then refreshes the panel
// continuously. Each row is sent as a DDRAM address command followed by COLS
// data writes.
//
// Ports:
//   clk, rst_n          system clock (rising edge), asynchronous active-low reset
//   wr_en/wr_addr/wr_data
//                       CPU character write; the address is row*COLS+col, and
//                       out-of-range addresses are ignored
//   clear_req           fill the buffer with spaces in one cycle (wins over wr_en)
//   EN, RW, RS, data    LCD pins; RW is tied low
//   ready               high from the first row command onward
//   frame_done          one-cycle pulse on the last cycle of each frame
//
// Optional feature (macro LCD_DIRTY_SKIP_EN): refresh only when the buffer has
// been touched since row 0 of the previous frame went out. Otherwise the FSM
// idles with EN low.
module lcd_frame_ctrl #(
  parameter int ROWS     = 2,
  parameter int COLS     = 16,
  parameter int EN_CYC   = 50_000,
  parameter int WAIT_CYC = 50_000,
  parameter int CLR_CYC  = 100_000,
  parameter int POR_CYC  = 750_000,
  localparam int CELLS   = ROWS * COLS,
  localparam int AW      = $clog2(CELLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          clear_req,
  output logic          EN,
  output logic          RW,
  output logic          RS,
  output logic [7:0]    data,
  output logic          ready,
  output logic          frame_done
);

  localparam logic [31:0] EN_LAST   = 32'(EN_CYC - 1);
  localparam logic [31:0] WAIT_LAST = 32'(WAIT_CYC - 1);
  localparam logic [31:0] CLR_LAST  = 32'(CLR_CYC - 1);
  localparam logic [31:0] POR_LAST  = 32'(POR_CYC - 1);
  localparam logic [AW:0] NCELL     = (AW+1)'(CELLS);
  localparam logic [5:0]  COL_LAST  = 6'(COLS - 1);
  localparam logic [1:0]  ROW_LAST  = 2'(ROWS - 1);

  typedef enum logic [2:0] {S_POR, S_INIT, S_ROW_CMD, S_CHAR, S_IDLE} state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] row_cmd(input logic [1:0] r);
    case (r)
      2'd0:    row_cmd = 8'h80;
      2'd1:    row_cmd = 8'hC0;
      2'd2:    row_cmd = 8'h94;
      default: row_cmd = 8'hD4;
    endcase
  endfunction

  // ---------------- frame buffer ----------------
  logic [CELLS-1:0][7:0] fb;
  logic                  wr_ok;
  assign wr_ok = wr_en && ({1'b0, wr_addr} < NCELL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          fb <= {CELLS{8'h20}};
    else if (clear_req)  fb <= {CELLS{8'h20}};
    else if (wr_ok)      fb[wr_addr] <= wr_data;
  end

  // ---------------- sequencer ----------------
  state_t        state, n_state;
  logic          hi;          // 1 = EN-high phase of the current transaction
  logic [31:0]   cnt;
  logic [1:0]    init_idx, n_init;
  logic [1:0]    row, n_row;
  logic [5:0]    col, n_col;
  logic [AW-1:0] ptr, n_ptr;  // address of the next character to send
  logic          is_clr, n_clr;
  logic          n_rs;
  logic [7:0]    n_data;
  logic          launch, go_idle, fd_next;
  logic          hi_done, lo_done, last_char;
  logic [31:0]   lo_last;
  logic          skip_frame, wake;

`ifdef LCD_DIRTY_SKIP_EN
  logic dirty;
  assign skip_frame = !dirty;
  assign wake       = dirty;

  // A write on the same edge as the row-0 launch keeps the flag set, so that
  // write is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  dirty <= 1'b0;
    else if (clear_req || wr_ok)                 dirty <= 1'b1;
    else if (launch && n_state == S_ROW_CMD &&
             n_row == 2'd0)                      dirty <= 1'b0;
  end
`else
  assign skip_frame = 1'b0;
  assign wake       = 1'b0;
`endif

  assign lo_last   = is_clr ? CLR_LAST : WAIT_LAST;
  assign hi_done   = hi && (cnt == EN_LAST);
  assign lo_done   = !hi && (cnt == lo_last);
  assign last_char = (state == S_CHAR) && (col == COL_LAST) && (row == ROW_LAST);
  // frame_done must cover the final low cycle of the last character, so it is
  // raised one cycle before that cycle begins.
  assign fd_next   = last_char && ((hi_done && lo_last == 32'd0) ||
                                   (!hi && (cnt + 32'd1 == lo_last)));

  always_comb begin
    launch  = 1'b0;
    go_idle = 1'b0;
    n_state = state;
    n_rs    = 1'b0;
    n_data  = 8'h00;
    n_init  = init_idx;
    n_row   = row;
    n_col   = col;
    n_ptr   = ptr;
    n_clr   = 1'b0;
    case (state)
      S_POR: if (cnt == POR_LAST) begin
        launch  = 1'b1;
        n_state = S_INIT;
        n_init  = 2'd0;
        n_data  = init_cmd(2'd0);
      end
      S_INIT: if (lo_done) begin
        launch = 1'b1;
        if (init_idx == 2'd3) begin
          n_state = S_ROW_CMD;
          n_row   = 2'd0;
          n_ptr   = '0;
          n_data  = row_cmd(2'd0);
        end else begin
          n_init = init_idx + 2'd1;
          n_data = init_cmd(init_idx + 2'd1);
          n_clr  = (init_idx == 2'd2);
        end
      end
      S_ROW_CMD: if (lo_done) begin
        launch  = 1'b1;
        n_state = S_CHAR;
        n_rs    = 1'b1;
        n_col   = 6'd0;
        n_data  = fb[ptr];
        n_ptr   = ptr + 1'b1;
      end
      S_CHAR: if (lo_done) begin
        if (col != COL_LAST) begin
          launch  = 1'b1;
          n_rs    = 1'b1;
          n_col   = col + 6'd1;
          n_data  = fb[ptr];
          n_ptr   = ptr + 1'b1;
        end else if (row != ROW_LAST) begin
          launch  = 1'b1;
          n_state = S_ROW_CMD;
          n_row   = row + 2'd1;
          n_data  = row_cmd(row + 2'd1);
        end else if (skip_frame) begin
          go_idle = 1'b1;
        end else begin
          launch  = 1'b1;
          n_state = S_ROW_CMD;
          n_row   = 2'd0;
          n_ptr   = '0;
          n_data  = row_cmd(2'd0);
        end
      end
      S_IDLE: if (wake) begin
        launch  = 1'b1;
        n_state = S_ROW_CMD;
        n_row   = 2'd0;
        n_ptr   = '0;
        n_data  = row_cmd(2'd0);
      end
      default: ;
    endcase
  end

  assign RW = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_POR;
      hi         <= 1'b0;
      cnt        <= '0;
      init_idx   <= '0;
      row        <= '0;
      col        <= '0;
      ptr        <= '0;
      is_clr     <= 1'b0;
      EN         <= 1'b0;
      RS         <= 1'b0;
      data       <= 8'h00;
      ready      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= fd_next;
      if (launch) begin
        state    <= n_state;
        hi       <= 1'b1;
        cnt      <= '0;
        EN       <= 1'b1;
        RS       <= n_rs;
        data     <= n_data;
        init_idx <= n_init;
        row      <= n_row;
        col      <= n_col;
        ptr      <= n_ptr;
        is_clr   <= n_clr;
        if (n_state == S_ROW_CMD) ready <= 1'b1;
      end else if (go_idle) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else if (hi_done) begin
        hi  <= 1'b0;
        cnt <= '0;
        EN  <= 1'b0;
      end else if (state != S_IDLE) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule
